// File: rtl/floppy_pkg.sv
// Shared types and default timing for the floppy drive mechanical model.
package floppy_pkg;

  typedef enum logic [1:0] {
    M_OFF    = 2'd0,
    M_SPINUP = 2'd1,
    M_RUN    = 2'd2
  } motor_st_e;

  // Host control lines as they appear on the bus (all active-low).
  typedef struct packed {
    logic step_n;
    logic dir_n;
    logic motor_n;
    logic sel_n;
    logic side_n;
  } host_in_t;

  localparam int unsigned HOST_W          = $bits(host_in_t);
  localparam int unsigned CYL_W           = 7;
  localparam int unsigned DEF_CLK_HZ      = 50_000_000;
  localparam int unsigned DEF_NUM_CYL     = 80;
  localparam int unsigned DEF_REV_CYC     = 10_000_000;
  localparam int unsigned DEF_INDEX_CYC   = 100_000;
  localparam int unsigned DEF_SPINUP_CYC  = 25_000_000;
  localparam int unsigned DEF_STEP_GUARD  = 150_000;

  // One head step, clamped to the physical cylinder range.
  function automatic logic [CYL_W-1:0] step_cyl(input logic [CYL_W-1:0] cur,
                                                input logic             inward,
                                                input logic [CYL_W-1:0] top);
    if (inward) return (cur == top) ? cur : cur + 1'b1;
    return (cur == '0) ? cur : cur - 1'b1;
  endfunction

endpackage

// File: rtl/floppy_drive_state_if.sv
// Floppy bus between host controller and the emulated drive.
interface floppy_drive_state_if;
  logic step_n;
  logic dir_n;
  logic motor_n;
  logic sel_n;
  logic side_n;
  logic index_n;
  logic trk00_n;
  logic ready_n;

  modport master (output step_n, dir_n, motor_n, sel_n, side_n,
                  input  index_n, trk00_n, ready_n);
  modport slave  (input  step_n, dir_n, motor_n, sel_n, side_n,
                  output index_n, trk00_n, ready_n);
endinterface

// File: rtl/floppy_sync.sv
// Two-flop synchroniser for asynchronous host lines, with a per-bit reset value.
module floppy_sync #(
  parameter int unsigned   W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      q_o    <= RST_VAL;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/floppy_drive_state.sv
// Drive-side mechanics: head stepping, spindle/motor model and bus status lines.
module floppy_drive_state
  import floppy_pkg::*;
#(
  parameter int unsigned CLK_HZ     = DEF_CLK_HZ,
  parameter int unsigned NUM_CYL    = DEF_NUM_CYL,
  parameter int unsigned REV_CYC    = DEF_REV_CYC,
  parameter int unsigned INDEX_CYC  = DEF_INDEX_CYC,
  parameter int unsigned SPINUP_CYC = DEF_SPINUP_CYC,
  parameter int unsigned STEP_GUARD = DEF_STEP_GUARD
) (
  input  logic             clk,
  input  logic             rst_n,
  floppy_drive_state_if.slave bus,
  output logic [CYL_W-1:0] cyl,
  output logic             head,
  output logic             track_changed,
  output logic             rev_start
);

  if (CLK_HZ == 0 || NUM_CYL < 2 || NUM_CYL > (1 << CYL_W) || STEP_GUARD == 0 ||
      SPINUP_CYC == 0 || INDEX_CYC >= REV_CYC) begin : g_bad_cfg
    $error("floppy_drive_state: inconsistent timing/geometry parameters");
  end

  localparam logic [CYL_W-1:0] CYL_MAX = CYL_W'(NUM_CYL - 1);

  host_in_t raw, hs;
  logic     sel, motor;

  assign raw = '{step_n: bus.step_n, dir_n: bus.dir_n, motor_n: bus.motor_n,
                 sel_n: bus.sel_n, side_n: bus.side_n};

  floppy_sync #(.W(HOST_W), .RST_VAL('1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (raw),
    .q_o   (hs)
  );

  assign sel   = ~hs.sel_n;
  assign motor = ~hs.motor_n;

  // ---------------- head positioning ----------------
  logic             step_prev_q, step_go_q, step_in_q;
  logic             tc_q, trk00_n_q, head_q;
  logic [31:0]      guard_q;
  logic [CYL_W-1:0] cyl_q, cyl_d;
  logic             step_acc;

  // Guard counts down from the accepted edge; zero means the next edge may land.
  assign step_acc = sel && step_prev_q && !hs.step_n && (guard_q == 32'd0);

  always_comb begin
    cyl_d = cyl_q;
    if (step_go_q) cyl_d = step_cyl(cyl_q, step_in_q, CYL_MAX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      step_prev_q <= 1'b1;
      step_go_q   <= 1'b0;
      step_in_q   <= 1'b0;
      guard_q     <= '0;
      cyl_q       <= '0;
      tc_q        <= 1'b0;
      trk00_n_q   <= 1'b1;
      head_q      <= 1'b0;
    end else begin
      step_prev_q <= hs.step_n;
      step_go_q   <= step_acc;
      step_in_q   <= ~hs.dir_n;
      if (step_acc)            guard_q <= STEP_GUARD - 1;
      else if (guard_q != '0)  guard_q <= guard_q - 1;
      cyl_q       <= cyl_d;
      tc_q        <= (cyl_d != cyl_q);
      trk00_n_q   <= ~(sel && cyl_q == '0);
      head_q      <= ~hs.side_n;
    end
  end

  // ---------------- spindle motor ----------------
  motor_st_e   st_q;
  logic [31:0] spin_q, rev_q, rev_nxt;
  logic        index_n_q, ready_n_q, rs_q;

  assign rev_nxt = (rev_q == REV_CYC - 1) ? '0 : rev_q + 1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q      <= M_OFF;
      spin_q    <= '0;
      rev_q     <= '0;
      index_n_q <= 1'b1;
      ready_n_q <= 1'b1;
      rs_q      <= 1'b0;
    end else begin
      // Index only exists while the disk turns; rev_q idles at 0 in OFF.
      index_n_q <= ~(sel && st_q != M_OFF && rev_q < INDEX_CYC);
      ready_n_q <= ~(sel && st_q == M_RUN);
      rs_q      <= (st_q == M_RUN) && (rev_q == '0);
      unique case (st_q)
        M_OFF: begin
          spin_q <= '0;
          rev_q  <= '0;
          if (motor) st_q <= M_SPINUP;
        end
        M_SPINUP: begin
          if (!motor) begin
            st_q   <= M_OFF;
            spin_q <= '0;
            rev_q  <= '0;
          end else begin
            spin_q <= spin_q + 1;
            rev_q  <= rev_nxt;
            if (spin_q == SPINUP_CYC - 1) st_q <= M_RUN;
          end
        end
        M_RUN: begin
          if (!motor) begin
            st_q   <= M_OFF;
            spin_q <= '0;
            rev_q  <= '0;
          end else begin
            rev_q  <= rev_nxt;
          end
        end
        default: st_q <= M_OFF;
      endcase
    end
  end

  assign bus.index_n   = index_n_q;
  assign bus.trk00_n   = trk00_n_q;
  assign bus.ready_n   = ready_n_q;
  assign cyl           = cyl_q;
  assign head          = head_q;
  assign track_changed = tc_q;
  assign rev_start     = rs_q;

endmodule

// File: tb/tb_floppy_drive_state.sv
// Randomised bench for floppy_drive_state against a step/motor reference model.
module tb_floppy_drive_state;

  localparam int REV    = 1000;
  localparam int IDX    = 20;
  localparam int SPIN   = 500;
  localparam int GUARD  = 30;
  localparam int NCYL   = 80;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] cyl;
  logic       head, track_changed, rev_start;

  floppy_drive_state_if bus();

  floppy_drive_state #(
    .CLK_HZ(50_000_000), .NUM_CYL(NCYL), .REV_CYC(REV),
    .INDEX_CYC(IDX), .SPINUP_CYC(SPIN), .STEP_GUARD(GUARD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .cyl(cyl), .head(head),
    .track_changed(track_changed), .rev_start(rev_start)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tc_cnt = 0;
  always @(negedge clk) if (rst_n && track_changed) tc_cnt = tc_cnt + 1;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference model: head position, last accepted step time, select, pulse tally.
  int m_cyl = 0, m_last = 0, m_tc = 0;
  bit m_have = 0, m_sel = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input bit v);
    bus.sel_n = !v;
    m_sel = v;
    tick(4);
  endtask

  // Falling step edge now, held low 3 clocks; next call's edge lands 'gap' clocks later.
  task automatic step(input bit inward, input int gap);
    int t, nc;
    t = cyc;
    bus.dir_n  = !inward;
    bus.step_n = 1'b0;
    if (m_sel && (!m_have || t - m_last >= GUARD)) begin
      m_have = 1; m_last = t;
      nc = inward ? ((m_cyl + 1 > NCYL - 1) ? NCYL - 1 : m_cyl + 1)
                  : ((m_cyl - 1 < 0) ? 0 : m_cyl - 1);
      if (nc != m_cyl) m_tc++;
      m_cyl = nc;
    end
    tick(3);
    bus.step_n = 1'b1;
    tick(gap - 3);
  endtask

  function automatic logic exp_trk00_n();
    return !(m_sel && m_cyl == 0);
  endfunction

  initial begin
    int tc0, d, lows, span;
    bit inw, sv, sd;
    int falls[$], rises[$], rss[$];
    logic prev;

    bus.step_n = 1; bus.dir_n = 1; bus.motor_n = 1; bus.sel_n = 1; bus.side_n = 1;
    tick(3);
    chk("rst_trk00_n", bus.trk00_n, 1);
    chk("rst_ready_n", bus.ready_n, 1);
    chk("rst_index_n", bus.index_n, 1);
    chk("rst_cyl", cyl, 0);
    chk("rst_head", head, 0);
    chk("rst_tc", track_changed, 0);
    chk("rst_rs", rev_start, 0);
    rst_n = 1'b1;
    tick(2);
    set_sel(1);
    chk("sel_trk00_n", bus.trk00_n, 0);
    chk("sel_ready_n", bus.ready_n, 1);

    // inward then outward stepping
    tc0 = tc_cnt;
    for (int i = 0; i < 5; i++) step(1, 40);
    chk("in_cyl", cyl, m_cyl);
    chk("in_tc", tc_cnt - tc0, 5);
    chk("in_trk00_n", bus.trk00_n, exp_trk00_n());
    tc0 = tc_cnt;
    for (int i = 0; i < 10; i++) step(0, 40);
    chk("out_cyl", cyl, m_cyl);
    chk("out_tc", tc_cnt - tc0, 5);
    chk("out_trk00_n", bus.trk00_n, exp_trk00_n());

    // guard window and deselected steps
    step(1, 10);
    step(1, 40);
    chk("guard_cyl", cyl, m_cyl);
    chk("guard_tc", tc_cnt, m_tc);
    set_sel(0);
    tc0 = tc_cnt;
    step(1, 40);
    chk("desel_cyl", cyl, m_cyl);
    chk("desel_tc", tc_cnt - tc0, 0);
    set_sel(1);

    // saturation at the inner stop
    for (int i = 0; i < NCYL && m_cyl > 0; i++) step(0, 40);
    tc0 = tc_cnt; d = m_tc;
    for (int i = 0; i < 85; i++) step(1, 40);
    chk("sat_cyl", cyl, m_cyl);
    chk("sat_tc", tc_cnt - tc0, m_tc - d);
    chk("sat_trk00_n", bus.trk00_n, exp_trk00_n());

    // random stepping, select and side
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        sv = !m_sel;
        set_sel(sv);
      end
      sd  = 1'($urandom_range(0, 1));
      inw = ($urandom_range(0, 2) == 0);
      bus.side_n = sd;
      step(inw, $urandom_range(6, 50));
      chk("rnd_cyl", cyl, m_cyl);
      chk("rnd_trk00_n", bus.trk00_n, exp_trk00_n());
      chk("rnd_head", head, !sd);
    end
    chk("rnd_tc", tc_cnt, m_tc);
    set_sel(1);

    // motor spin-up
    bus.motor_n = 1'b0;
    tc0 = cyc;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (bus.ready_n == 1'b0) break;
    end
    d = cyc - tc0;
    chk("spinup_lat", (d >= SPIN + 2 && d <= SPIN + 4) ? SPIN + 3 : d, SPIN + 3);

    prev = bus.index_n;
    for (int i = 0; i < 3200; i++) begin
      @(posedge clk); #1;
      if (prev && !bus.index_n) falls.push_back(cyc);
      if (!prev && bus.index_n) rises.push_back(cyc);
      if (rev_start) rss.push_back(cyc);
      prev = bus.index_n;
    end
    chk("idx_falls", (falls.size() >= 3) ? 3 : falls.size(), 3);
    chk("rs_count", (rss.size() >= 3) ? 3 : rss.size(), 3);
    for (int k = 0; k < 3 && k < falls.size(); k++) begin
      span = -1;
      foreach (rises[j]) if (span < 0 && rises[j] > falls[k]) span = rises[j] - falls[k];
      chk("idx_width", span, IDX);
      if (k + 1 < falls.size()) chk("idx_period", falls[k+1] - falls[k], REV);
      if (k < rss.size()) chk("rs_at_index", rss[k], falls[k]);
      if (k + 1 < rss.size()) chk("rs_period", rss[k+1] - rss[k], REV);
    end

    // motor off in the middle of an index pulse
    for (int i = 0; i < 1100; i++) begin
      if (bus.index_n == 1'b0) break;
      tick(1);
    end
    chk("moff_idx_seen", bus.index_n, 0);
    tick(5);
    bus.motor_n = 1'b1;
    tick(4);
    chk("moff_index_n", bus.index_n, 1);
    chk("moff_ready_n", bus.ready_n, 1);
    lows = 0;
    for (int i = 0; i < 1100; i++) begin
      tick(1);
      if (!bus.index_n || !bus.ready_n || rev_start) lows++;
    end
    chk("off_quiet", lows, 0);

    // deselect while running
    bus.motor_n = 1'b0;
    for (int i = 0; i < 700; i++) begin
      if (bus.ready_n == 1'b0) break;
      tick(1);
    end
    chk("run2_ready_n", bus.ready_n, 0);
    set_sel(0);
    lows = 0;
    for (int i = 0; i < 1100; i++) begin
      tick(1);
      if (!bus.index_n || !bus.ready_n || !bus.trk00_n) lows++;
    end
    chk("desel_status", lows, 0);
    chk("desel_keep_cyl", cyl, m_cyl);
    set_sel(1);
    chk("resel_ready_n", bus.ready_n, 0);
    chk("resel_trk00_n", bus.trk00_n, exp_trk00_n());

    // reset while spinning
    rst_n = 1'b0;
    #1;
    m_cyl = 0; m_have = 0;
    chk("rst2_cyl", cyl, m_cyl);
    chk("rst2_ready_n", bus.ready_n, 1);
    chk("rst2_index_n", bus.index_n, 1);
    chk("rst2_trk00_n", bus.trk00_n, 1);
    chk("rst2_head", head, 0);
    tick(2);
    rst_n = 1'b1;
    tick(6);
    chk("rst2_trk00_sel", bus.trk00_n, exp_trk00_n());
    chk("rst2_still_off", bus.ready_n, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
